pipe_flow_ctrl: RTL and testbench
=================================

PIPE_FLOW_CTRL -- requirements
Module: pipe_flow_ctrl

Interface
REQ-001 Parameters: DRAIN_CYC, default 3, cycles of bubble insertion after hlt before halted; CNT_W, default 16, perf counter width.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall_req  input  1  one-cycle load-use stall request from hazard detection, aligned to the instruction in ID.
REQ-005 flush_req  input  1  taken branch/jal/jr resolved in EX; squash IF/ID contents.
REQ-006 hlt_id  input  1  hlt opcode present in ID this cycle.
REQ-007 pc_we  output  1  PC register write enable.
REQ-008 ifid_we  output  1  IF/ID pipeline register write enable.
REQ-009 ifid_flush  output  1  load NOP into IF/ID at next edge.
REQ-010 idex_bubble  output  1  load NOP into ID/EX at next edge instead of decoded instruction.
REQ-011 halted  output  1  pipeline drained after hlt; registered.
REQ-012 stall_cnt  output  CNT_W  count of honored stall cycles.
REQ-013 flush_cnt  output  CNT_W  count of honored flushes.

Function
REQ-014 FSM states: RUN, STALL, DRAIN, HALT; encoding free; unreachable encodings SHALL go to RUN next cycle with RUN outputs.
REQ-015 Control outputs pc_we, ifid_we, ifid_flush, idex_bubble SHALL be combinational from state and current inputs (zero-cycle response).
REQ-016 RUN, no request: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0; stay RUN.
REQ-017 Priority in RUN: flush_req > stall_req > hlt_id.
REQ-018 RUN with flush_req: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1; flush_cnt+1; stay RUN; concurrent stall_req and hlt_id ignored (not counted).
REQ-019 RUN with stall_req, no flush_req: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1; stall_cnt+1; next STALL.
REQ-020 STALL: outputs as RUN-no-request; stall_req ignored (not counted); flush_req honored exactly as REQ-018; hlt_id honored as REQ-021; next state RUN unless REQ-021 applies.
REQ-021 RUN or STALL with hlt_id, no higher-priority request: outputs as RUN-no-request (hlt advances to EX); load drain counter with DRAIN_CYC-1; next DRAIN.
REQ-022 DRAIN: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1; counter decrements each cycle; when counter=0, next HALT; stall_req, flush_req, hlt_id ignored and not counted.
REQ-023 DRAIN lasts exactly DRAIN_CYC cycles; halted rises at the edge ending the last DRAIN cycle.
REQ-024 HALT: all four control outputs 0; halted=1; all inputs ignored; exit only via reset.
REQ-025 stall_cnt and flush_cnt SHALL saturate at all-ones, never wrap.
REQ-026 Counters SHALL not change in DRAIN or HALT.

Reset
REQ-027 rst_n low SHALL immediately force state RUN, drain counter 0, halted=0, stall_cnt=0, flush_cnt=0, independent of clk.
REQ-028 While rst_n low, control outputs SHALL equal RUN-no-request values gated by inputs per REQ-016..019, with no state or counter update.
REQ-029 Reset asserted mid-DRAIN or in HALT SHALL abandon drain; first cycle after release is RUN.

Verification
REQ-030 Load-use: stall_req=1 for one cycle in RUN -> that cycle pc_we=0, ifid_we=0, idex_bubble=1; next cycle RUN outputs; stall_cnt=1.
REQ-031 Back-to-back stall_req two cycles -> only first honored; second cycle pc_we=1, idex_bubble=0; stall_cnt=1.
REQ-032 flush_req and stall_req same cycle -> ifid_flush=1, idex_bubble=1, pc_we=1; flush_cnt=1, stall_cnt=0; next cycle RUN.
REQ-033 hlt_id one cycle, DRAIN_CYC=3 -> next 3 cycles pc_we=0, idex_bubble=1; halted=1 from 4th cycle after hlt_id onward; later flush_req/stall_req ignored, counters frozen.
REQ-034 Force stall_cnt to 16'hFFFE, two spaced stall_req -> stall_cnt 16'hFFFF then stays 16'hFFFF.
REQ-035 rst_n low during DRAIN cycle 2 -> halted stays 0, counters 0 immediately; after release, RUN outputs and normal stall response.

Source files
------------

// File: rtl/pipe_flow_ctrl.sv
// rtl/pipe_flow_ctrl.sv - pipeline stall/flush/halt flow controller with saturating perf counters
module pipe_flow_ctrl #(
    parameter int unsigned DRAIN_CYC = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_req,
    input  logic             flush_req,
    input  logic             hlt_id,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_inc, flush_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            drain_q     <= '0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        state_d     = state_q;
        drain_d     = drain_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        case (state_q)
            RUN: begin
                if (flush_req) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    flush_inc   = 1'b1;
                    state_d     = RUN;
                end else if (stall_req) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                    state_d     = STALL;
                end else if (hlt_id) begin
                    drain_d = DRAIN_LOAD;
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            // The stalled instruction proceeds now, so a repeated stall_req is the same hazard.
            STALL: begin
                if (flush_req) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    flush_inc   = 1'b1;
                    state_d     = RUN;
                end else if (hlt_id) begin
                    drain_d = DRAIN_LOAD;
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                if (drain_q == '0) begin
                    state_d = HALT;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            HALT: begin
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        halted_d    = (state_d == HALT);
        stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb/tb_pipe_flow_ctrl.sv - directed vector bench for pipe_flow_ctrl
module tb_pipe_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, stall_req, flush_req, hlt_id;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble, halted;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_rst_n, s_stall, s_flush, s_hlt;
    logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_bubble, s_halted;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_flow_ctrl #(.DRAIN_CYC(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .flush_req(flush_req),
        .hlt_id(hlt_id), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .halted(halted), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    // Narrow counters make saturation reachable in a handful of cycles.
    pipe_flow_ctrl #(.DRAIN_CYC(1), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(s_rst_n), .stall_req(s_stall), .flush_req(s_flush),
        .hlt_id(s_hlt), .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush),
        .idex_bubble(s_idex_bubble), .halted(s_halted), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        logic rst_n, stall, flush, hlt;
        logic pc, ifid, fl, bub, hal;
        int   sc, fc;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic h);
        @(posedge clk);
        #1;
        rst_n = r; stall_req = s; flush_req = f; hlt_id = h;
        #3;
    endtask

    task automatic chk_main(input string tag, input logic pc, input logic ifid,
                            input logic fl, input logic bub, input logic hal,
                            input int sc, input int fc);
        chk({tag, ".pc_we"},       int'(pc_we),       int'(pc));
        chk({tag, ".ifid_we"},     int'(ifid_we),     int'(ifid));
        chk({tag, ".ifid_flush"},  int'(ifid_flush),  int'(fl));
        chk({tag, ".idex_bubble"}, int'(idex_bubble), int'(bub));
        chk({tag, ".halted"},      int'(halted),      int'(hal));
        chk({tag, ".stall_cnt"},   int'(stall_cnt),   sc);
        chk({tag, ".flush_cnt"},   int'(flush_cnt),   fc);
    endtask

    task automatic s_drive(input logic s, input logic f, input logic h);
        @(posedge clk);
        #1;
        s_stall = s; s_flush = f; s_hlt = h;
        #3;
    endtask

    initial begin
        rst_n = 1'b0; stall_req = 1'b0; flush_req = 1'b0; hlt_id = 1'b0;
        s_rst_n = 1'b0; s_stall = 1'b0; s_flush = 1'b0; s_hlt = 1'b0;

        //          rst  stl  fls  hlt   pc  ifid fl  bub hal  sc fc
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, 0, 0};
        vecs[1]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0, 0, 0};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, 0, 0};
        vecs[3]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0, 0, 0};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, 1, 0};
        vecs[5]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0, 1, 0};
        vecs[6]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, 2, 0};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, 2, 0};
        vecs[8]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b0, 2, 0};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, 2, 1};
        vecs[10] = '{1'b1,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b1,1'b1,1'b0, 2, 1};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0, 2, 2};
        vecs[12] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b0, 3, 2};
        vecs[13] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, 3, 3};
        vecs[14] = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0, 3, 3};
        vecs[15] = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0, 3, 3};
        vecs[16] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0, 3, 3};
        vecs[17] = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0, 3, 3};
        vecs[18] = '{1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1, 3, 3};
        vecs[19] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 3, 3};
        vecs[20] = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, 0, 0};
        vecs[21] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, 0, 0};

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rst_n, vecs[i].stall, vecs[i].flush, vecs[i].hlt);
            chk_main($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ifid, vecs[i].fl,
                     vecs[i].bub, vecs[i].hal, vecs[i].sc, vecs[i].fc);
        end

        // hlt arriving while in STALL still starts the drain
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk_main("sh_stall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        chk_main("sh_hlt",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            chk_main($sformatf("sh_drain%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_main("sh_halt",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);

        // reset asserted in the second drain cycle, off the clock edge
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        chk_main("rd_hlt",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_main("rd_drain1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_main("rd_drain2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
        rst_n = 1'b0;
        #1;
        chk_main("rd_async", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_main("rd_run",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_main("rd_run2",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk_main("rd_stall",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_main("rd_after",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);

        // saturation on the 2-bit instance, then a one-cycle drain
        @(posedge clk);
        #1;
        s_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_drive(1'b1, 1'b0, 1'b0);
            s_drive(1'b0, 1'b0, 1'b0);
            chk($sformatf("sat_stall%0d", i), int'(s_stall_cnt), (i + 1 > 3) ? 3 : i + 1);
        end
        for (int i = 0; i < 5; i++) begin
            s_drive(1'b0, 1'b1, 1'b0);
            s_drive(1'b0, 1'b0, 1'b0);
            chk($sformatf("sat_flush%0d", i), int'(s_flush_cnt), (i + 1 > 3) ? 3 : i + 1);
        end
        s_drive(1'b0, 1'b0, 1'b1);
        s_drive(1'b1, 1'b1, 1'b0);
        chk("s_drain.bub",   int'(s_idex_bubble), 1);
        chk("s_drain.pc_we", int'(s_pc_we), 0);
        chk("s_drain.hal",   int'(s_halted), 0);
        s_drive(1'b0, 1'b0, 1'b0);
        chk("s_halt.hal",    int'(s_halted), 1);
        chk("s_halt.bub",    int'(s_idex_bubble), 0);
        chk("s_halt.ifid",   int'(s_ifid_we), 0);
        chk("s_halt.fl",     int'(s_ifid_flush), 0);
        chk("s_halt.sc",     int'(s_stall_cnt), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
